// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;

    localparam int FETCH_BUF_DEPTH = 2;
    localparam int FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);
    localparam logic [FETCH_CNT_W-1:0] FETCH_BUF_FULL = FETCH_CNT_W'(FETCH_BUF_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding fetched words until decode accepts them.
// The head entry is a register so decode sees a stable word under back-pressure.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [FETCH_CNT_W-1:0] count,
    output fetch_entry_t           head
);

    fetch_entry_t tail;
    logic         pop_eff;
    logic         push_eff;

    // Qualify requests: never pop an empty buffer, never overfill it.
    always_comb begin
        pop_eff  = pop && (count != '0);
        push_eff = push && ((count != FETCH_BUF_FULL) || pop_eff);
    end

    // FIFO storage and occupancy; a flush empties the buffer outright.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push_eff, pop_eff})
                2'b11: begin
                    if (count == FETCH_CNT_W'(1)) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                2'b10: begin
                    if (count == '0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    count <= count + FETCH_CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - FETCH_CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for a synchronous-read instruction memory.
// Owns the PC, issues at most one fetch per cycle within buffer credit, tags
// returned words with their PC and flushes everything on a redirect.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic        fetch_active
);

    state_t                 state;
    state_t                 next_state;
    logic [31:0]            pc;
    logic [31:0]            req_pc;
    logic                   inflight;
    logic [FETCH_CNT_W-1:0] occ;
    fetch_entry_t           head;
    fetch_entry_t           push_data;
    logic                   redirect;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [2:0]             credit;

    // State register: IDLE lasts exactly one cycle after reset releases.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the per-cycle fetch decisions.
    always_comb begin
        next_state = state;
        redirect   = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        issue      = 1'b0;
        credit     = 3'd0;
        imem_addr  = pc;
        if (state == IDLE) begin
            next_state = RUN;
        end else begin
            redirect = redirect_valid;
            // A redirect flushes the buffer, so decode's accept is moot that cycle.
            pop      = out_valid && out_ready && !redirect_valid;
            // The word returning during a redirect belongs to the abandoned path.
            push     = inflight && !redirect_valid;
            credit   = 3'(occ) + 3'(inflight) - 3'(pop);
            issue    = redirect_valid || (credit <= 3'd1);
            if (redirect_valid) begin
                imem_addr = redirect_pc & ~32'h3;
            end
        end
    end

    // PC, outstanding request tag and in-flight flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= imem_addr;
                pc     <= imem_addr + PC_STEP;
            end
        end
    end

    assign push_data = '{pc: req_pc, instr: imem_rdata};

    fetch_skid_buffer u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (occ),
        .head      (head)
    );

    assign out_valid    = (occ != '0);
    assign out_pc       = head.pc;
    assign out_instr    = head.instr;
    assign fetch_active = issue;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized scoreboard bench for fetch_controller.
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        fetch_active;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    exp_t        sbq[$];
    logic [31:0] sb_next;

    fetch_controller dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready),
        .fetch_active   (fetch_active)
    );

    always #5 clock = ~clock;

    // Program image: word at byte address a holds 0x1000 + word index.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h1000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous-read memory; output is garbage while reset is held.
    always @(posedge clock) begin
        if (reset) imem_rdata <= $urandom;
        else       imem_rdata <= memword(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected program-order stream from the current start point.
    task automatic sb_fill();
        while (sbq.size() < 16) begin
            sbq.push_back('{pc: sb_next, instr: memword(sb_next)});
            sb_next = sb_next + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] start_pc);
        sbq.delete();
        sb_next = start_pc;
        sb_fill();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        sb_fill();
    endtask

    task automatic wait_first_valid(input int start, output int lat);
        lat = start;
        forever begin
            @(negedge clock);
            if (out_valid || lat >= 10) break;
            lat++;
            tick();
        end
    endtask

    // Monitor: every accepted word must be the next one in program order.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=pc %h expected=no word", out_pc);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", out_pc, e.pc);
                chk("sb_instr", out_instr, e.instr);
                pops++;
            end
        end
    end

    initial begin
        int          lat;
        logic [31:0] held_pc;
        logic [31:0] held_instr;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        sb_restart(RST_PC);
        repeat (2) tick();
        @(negedge clock);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_issue", 32'(fetch_active), 32'd0);

        // Release; a redirect during IDLE must be ignored.
        tick();
        reset          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        @(negedge clock);
        chk("idle_addr", imem_addr, RST_PC);
        chk("idle_issue", 32'(fetch_active), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        wait_first_valid(1, lat);
        chk("first_latency", 32'(lat), 32'd3);
        chk("first_pc", out_pc, RST_PC);
        chk("first_instr", out_instr, 32'h1000);

        // Full-throughput streaming.
        repeat (12) begin
            tick();
            @(negedge clock);
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_issue", 32'(fetch_active), 32'd1);
        end

        // Back-pressure: head must hold and fetching must stop.
        tick();
        out_ready = 1'b0;
        @(negedge clock);
        held_pc    = out_pc;
        held_instr = out_instr;
        repeat (5) begin
            tick();
            @(negedge clock);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, held_pc);
            chk("stall_instr", out_instr, held_instr);
        end
        chk("stall_no_issue", 32'(fetch_active), 32'd0);

        // Redirect with a full buffer, decode stalled.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        sb_restart(32'h0000_0200);
        @(negedge clock);
        chk("redir_addr", imem_addr, 32'h0000_0200);
        chk("redir_issue", 32'(fetch_active), 32'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("redir_flushed", 32'(out_valid), 32'd0);
        tick();
        @(negedge clock);
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", out_pc, 32'h0000_0200);
        chk("redir_instr", out_instr, 32'h0000_1080);

        // Redirect coinciding with out_ready on a full buffer.
        repeat (3) tick();
        tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0340;
        sb_restart(32'h0000_0340);
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("redir_pop_flushed", 32'(out_valid), 32'd0);
        tick();
        @(negedge clock);
        chk("redir_pop_pc", out_pc, 32'h0000_0340);

        // PC wrap at the top of the address space.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        sb_restart(32'hFFFF_FFFC);
        @(negedge clock);
        chk("wrap_redir_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        @(negedge clock);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_issue", 32'(fetch_active), 32'd1);
        repeat (6) tick();

        // Random back-pressure and redirects.
        repeat (400) begin
            tick();
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                sb_restart(redirect_pc & ~32'h3);
            end else begin
                redirect_valid = 1'b0;
            end
        end
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (4) tick();

        // Asynchronous reset between clock edges.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_pc", out_pc, 32'd0);
        chk("async_instr", out_instr, 32'd0);
        chk("async_issue", 32'(fetch_active), 32'd0);
        sb_restart(RST_PC);
        repeat (2) tick();
        reset = 1'b0;
        wait_first_valid(0, lat);
        chk("restart_latency", 32'(lat), 32'd3);
        chk("restart_pc", out_pc, RST_PC);
        chk("restart_instr", out_instr, 32'h1000);
        repeat (10) tick();
        chk("progress", 32'(pops >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
